// File: rtl/eth_tx_arbiter.sv
// Packet-granular arbiter sharing one 8-bit AXI-Stream MAC TX path between frame sources.
// Build option: define TX_ARB_STRICT_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module eth_tx_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*NUM_PORTS-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]   s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]   s_axis_tlast,
    output logic [NUM_PORTS-1:0]   s_axis_tready,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic [CNT_W-1:0]       tx_frame_cnt
);

    // state | meaning
    // IDLE  | no grant; outputs and readies held at 0; arbitrate on any tvalid
    // XFER  | granted port passed straight through until its TLAST beat
    typedef enum logic {IDLE, XFER} state_t;

    state_t     state;
    logic [2:0] grant;
    logic [2:0] search_start;
    logic [2:0] winner;
    logic [2:0] hi_idx;
    logic [2:0] lo_idx;
    logic       hi_found;
    logic       beat_last;

`ifndef TX_ARB_STRICT_PRIO_EN
    logic [2:0] last_grant;
    assign search_start = (last_grant >= 3'(NUM_PORTS-1)) ? 3'd0 : last_grant + 3'd1;
`else
    assign search_start = 3'd0;
`endif

    // Lowest valid index at/above the start point wins, else lowest valid below it (wrap).
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = 3'd0;
        lo_idx   = 3'd0;
        for (int p = NUM_PORTS-1; p >= 0; p--) begin
            if (s_axis_tvalid[p]) begin
                if (3'(p) >= search_start) begin
                    hi_found = 1'b1;
                    hi_idx   = 3'(p);
                end else begin
                    lo_idx = 3'(p);
                end
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        m_axis_tdata  = 8'd0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (state == XFER) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (grant == 3'(p)) begin
                    m_axis_tdata     = s_axis_tdata[8*p +: 8];
                    m_axis_tvalid    = s_axis_tvalid[p];
                    m_axis_tlast     = s_axis_tlast[p];
                    s_axis_tready[p] = m_axis_tready;
                end
            end
        end
    end

    assign beat_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign grant_id  = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= 3'd0;
            busy         <= 1'b0;
            tx_frame_cnt <= '0;
`ifndef TX_ARB_STRICT_PRIO_EN
            last_grant   <= 3'(NUM_PORTS-1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        grant <= winner;
                        state <= XFER;
                        busy  <= 1'b1;
                    end
                end
                XFER: begin
                    if (beat_last) begin
`ifndef TX_ARB_STRICT_PRIO_EN
                        last_grant <= grant;
`endif
                        tx_frame_cnt <= tx_frame_cnt + CNT_W'(1);
                        state        <= IDLE;
                        busy         <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Randomized self-checking bench for eth_tx_arbiter against a frame-level reference model.
module tb_eth_tx_arbiter;
    localparam int NP = 3;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [8*NP-1:0] s_axis_tdata;
    logic [NP-1:0]   s_axis_tvalid;
    logic [NP-1:0]   s_axis_tlast;
    logic [NP-1:0]   s_axis_tready;
    logic [7:0]      m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tready;
    logic            busy;
    logic [2:0]      grant_id;
    logic [CW-1:0]   tx_frame_cnt;

    always #5 clk = ~clk;

    eth_tx_arbiter #(.NUM_PORTS(NP), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .busy(busy), .grant_id(grant_id), .tx_frame_cnt(tx_frame_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Source byte streams (what the drivers present) and expected output streams per port.
    logic [7:0] src_d[NP][$];
    logic       src_l[NP][$];
    logic [7:0] exp_d[NP][$];
    logic       exp_l[NP][$];

    int   vprob  = 100;
    int   mprob  = 100;
    bit   pat_en = 1'b0;
    int   pat_i  = 0;
    bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic add_frame(input int p, input int len, input int base);
        for (int i = 0; i < len; i++) begin
            src_d[p].push_back(8'(base + i));
            exp_d[p].push_back(8'(base + i));
            src_l[p].push_back(i == len - 1);
            exp_l[p].push_back(i == len - 1);
        end
    endtask

    task automatic clear_queues();
        for (int p = 0; p < NP; p++) begin
            src_d[p].delete(); src_l[p].delete();
            exp_d[p].delete(); exp_l[p].delete();
        end
    endtask

    // Source and sink drivers
    initial begin
        logic [NP-1:0] hs;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        forever begin
            @(negedge clk);
            hs = s_axis_tvalid & s_axis_tready;
            @(posedge clk);
            #1;
            if (rst_n) begin
                for (int p = 0; p < NP; p++) begin
                    if (hs[p] && src_d[p].size() > 0) begin
                        void'(src_d[p].pop_front());
                        void'(src_l[p].pop_front());
                    end
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (src_d[p].size() > 0 && $urandom_range(99) < vprob) begin
                    s_axis_tvalid[p]       = 1'b1;
                    s_axis_tdata[8*p +: 8] = src_d[p][0];
                    s_axis_tlast[p]        = src_l[p][0];
                end else begin
                    s_axis_tvalid[p]       = 1'b0;
                    s_axis_tdata[8*p +: 8] = 8'd0;
                    s_axis_tlast[p]        = 1'b0;
                end
            end
            if (pat_en) begin
                m_axis_tready = pat[pat_i % 4];
                pat_i++;
            end else begin
                m_axis_tready = ($urandom_range(99) < mprob);
            end
        end
    end

    // Reference model: who owns the link, who owned it last, frames completed.
    bit m_busy;
    int m_g;
    int m_last;
    int m_cnt;
    int cyc = 0;

    function automatic int pick(input logic [NP-1:0] v, input int last);
        int start;
        start = (last + 1) % NP;
`ifdef TX_ARB_STRICT_PRIO_EN
        start = 0;
`endif
        for (int k = 0; k < NP; k++)
            if (v[(start + k) % NP]) return (start + k) % NP;
        return 0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_g    <= 0;
            m_last <= NP - 1;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (|s_axis_tvalid) begin
                m_g    <= pick(s_axis_tvalid, m_last);
                m_busy <= 1'b1;
            end
        end else if (s_axis_tvalid[m_g] && m_axis_tready && s_axis_tlast[m_g]) begin
            m_last <= m_g;
            m_cnt  <= (m_cnt + 1) % (1 << CW);
            m_busy <= 1'b0;
        end
    end

    // Per-cycle comparison and output-stream scoreboard
    int start_p[$];
    int start_c[$];
    int end_c[$];
    int out_beats = 0;
    bit mid = 1'b0;

    initial begin
        logic [NP-1:0] e_ready;
        logic          e_valid;
        forever begin
            @(negedge clk);
            e_ready = '0;
            e_valid = m_busy ? s_axis_tvalid[m_g] : 1'b0;
            if (m_busy) e_ready[m_g] = m_axis_tready;
            chk("m_tvalid", m_axis_tvalid, e_valid);
            chk("m_tdata", m_axis_tdata, m_busy ? s_axis_tdata[8*m_g +: 8] : 8'd0);
            chk("m_tlast", m_axis_tlast, m_busy ? s_axis_tlast[m_g] : 1'b0);
            chk("s_tready", s_axis_tready, e_ready);
            chk("busy", busy, m_busy);
            chk("grant_id", grant_id, m_g);
            chk("tx_frame_cnt", tx_frame_cnt, m_cnt);
            if (!rst_n) mid = 1'b0;
            if (rst_n && e_valid && m_axis_tready) begin
                out_beats++;
                if (!mid) begin
                    start_p.push_back(m_g);
                    start_c.push_back(cyc);
                end
                if (exp_d[m_g].size() == 0) begin
                    chk("sb_extra_beat", 1, 0);
                end else begin
                    chk("sb_byte", m_axis_tdata, exp_d[m_g].pop_front());
                    chk("sb_last", m_axis_tlast, exp_l[m_g].pop_front());
                end
                if (m_axis_tlast) end_c.push_back(cyc);
                mid = !m_axis_tlast;
            end
        end
    end

    task automatic drain(input int max);
        int n;
        bit pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < max) begin
            @(negedge clk);
            n++;
            pending = m_busy;
            for (int p = 0; p < NP; p++) if (src_d[p].size() > 0) pending = 1'b1;
        end
        if (pending) chk("drain_timeout", 1, 0);
    endtask

    task automatic clear_trace();
        start_p.delete(); start_c.delete(); end_c.delete();
        out_beats = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        clear_queues();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_cnt", tx_frame_cnt, 0);
        chk("rst_ready", s_axis_tready, 0);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        @(posedge clk); #3 rst_n = 1'b1;

        // Single-port 53-byte frame
        clear_trace();
        @(posedge clk);
        add_frame(1, 53, 8'h40);
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axis_tvalid[1] && n < 20);
        chk("t1_idle_on_request", busy, 0);
        @(negedge clk);
        chk("t1_first_valid", m_axis_tvalid, 1);
        chk("t1_first_byte", m_axis_tdata, 8'h40);
        drain(500);
        @(negedge clk);
        chk("t1_cnt", tx_frame_cnt, 1);
        chk("t1_busy", busy, 0);
        chk("t1_grant_id", grant_id, 1);
        chk("t1_beats", out_beats, 53);
        chk("t1_len_cycles", (end_c.size() > 0 && start_c.size() > 0) ? end_c[0] - start_c[0] : -1, 52);

        // Backpressure pattern on port 2
        clear_trace();
        pat_en = 1'b1; pat_i = 0;
        add_frame(2, 12, 8'h80);
        drain(300);
        pat_en = 1'b0;
        @(negedge clk);
        chk("t4_cnt", tx_frame_cnt, 2);
        chk("t4_grant_id", grant_id, 2);
        chk("t4_beats", out_beats, 12);
        chk("t4_sb_left", exp_d[2].size(), 0);

        // Reset at byte 10 of 20
        clear_trace();
        add_frame(0, 20, 8'hA0);
        n = 0;
        while (out_beats < 9 && n < 200) begin @(negedge clk); n++; end
        chk("t5_reached_byte9", out_beats, 9);
        @(posedge clk); #3;
        chk("t5_byte10", m_axis_tdata, 8'hA9);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tvalid", m_axis_tvalid, 0);
        chk("t5_rst_ready", s_axis_tready, 0);
        clear_queues();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Three-port contention after reset
        clear_trace();
        @(posedge clk);
        add_frame(0, 4, 8'h10);
        add_frame(1, 4, 8'h20);
        add_frame(2, 4, 8'h30);
        drain(200);
        @(negedge clk);
        chk("t2_frames", start_p.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("t2_order", (i < start_p.size()) ? start_p[i] : 99, i);
        for (int i = 0; i < 2; i++)
            chk("t2_gap", (i + 1 < start_c.size() && i < end_c.size()) ? start_c[i+1] - end_c[i] : -1, 2);
        chk("t2_cnt", tx_frame_cnt, 3);

`ifdef TX_ARB_STRICT_PRIO_EN
        clear_trace();
        @(posedge clk);
        for (int f = 0; f < 4; f++) add_frame(0, 3, 8'h50 + 4 * f);
        add_frame(2, 2, 8'h70);
        drain(300);
        for (int i = 0; i < 4; i++)
            chk("sp_port0_wins", (i < start_p.size()) ? start_p[i] : 99, 0);
        chk("sp_port2_last", (start_p.size() == 5) ? start_p[4] : 99, 2);
`endif

        // Counter wrap with one-byte frames
        do_reset();
        for (int f = 1; f <= 17; f++) begin
            clear_trace();
            add_frame($urandom_range(NP - 1), 1, f);
            drain(50);
            @(negedge clk);
            chk("t6_cnt", tx_frame_cnt, f % 16);
            chk("t6_one_cycle", (end_c.size() == 1 && start_c.size() == 1) ? end_c[0] - start_c[0] : -1, 0);
        end

        // Randomized traffic with valid gaps and MAC backpressure
        vprob = 70; mprob = 60;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 10; i++)
                add_frame($urandom_range(NP - 1), $urandom_range(1, 16), $urandom_range(255));
            drain(5000);
        end
        for (int p = 0; p < NP; p++) chk("t7_sb_left", exp_d[p].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Packet-granular arbiter that shares the single 8-bit AXI-Stream MAC transmit path between several frame sources, such as the ICMP echo engine, the ARP responder and the order-entry framer. It sits between those engines' master streams and the MAC TX interface. A grant is held from the first byte to the TLAST byte of a frame, so frames never interleave. Fairness between ports is round-robin by default.

## Interface
- NUM_PORTS, 3, number of requesting sources; legal range 2..8.
- CNT_W, 16, width of the transmitted-frame counter.

- clk  in  1  system clock (125 MHz MAC domain).
- rst_n  in  1  reset; asynchronous assert, active-low.
- s_axis_tdata  in  8*NUM_PORTS  flattened; port p occupies bits [8p+7:8p].
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port end of frame.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  8  to MAC.
- m_axis_tvalid  out  1  to MAC.
- m_axis_tlast  out  1  to MAC.
- m_axis_tready  in  1  from MAC.
- busy  out  1  high while a frame is granted (state XFER).
- grant_id  out  3  index of the granted port; holds the last granted index when idle.
- tx_frame_cnt  out  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

## Operation
- There are two states: IDLE and XFER.
- IDLE:
  - All s_axis_tready are 0. m_axis_tvalid, m_axis_tlast and m_axis_tdata are 0.
  - If any s_axis_tvalid is 1, select a winner and register it into grant. The next state is XFER.
  - Round-robin selection: the winner is the first port with tvalid set, searching from (last_grant+1) mod NUM_PORTS upward with wrap-around.
  - If no tvalid is set, stay in IDLE.
- XFER, combinational passthrough of the granted port g:
  - m_axis_tdata, m_axis_tvalid and m_axis_tlast equal port g's signals.
  - s_axis_tready[g] = m_axis_tready. All other ready bits are 0.
- A beat completes when m_axis_tvalid and m_axis_tready are both 1.
- On the beat with tlast=1:
  - Set last_grant = g.
  - Increment tx_frame_cnt.
  - The next state is IDLE.
- While in XFER, the granted port dropping tvalid mid-frame is legal: output valid drops and the grant is held. No timeout applies.
- Requests from other ports during XFER are ignored until the frame ends. They are not latched. A port is eligible only if its tvalid is high in IDLE.
- grant_id = grant, zero-extended to 3 bits.

## Timing
- Reset values:
  - State IDLE and grant 0.
  - last_grant = NUM_PORTS-1, so port 0 wins the first contention.
  - tx_frame_cnt = 0, busy = 0, grant_id = 0.
  - All s_axis_tready = 0, m_axis_tvalid = 0.
- Arbitration latency: if tvalid rises and is sampled in IDLE at edge N, then XFER is active after edge N and the first byte can transfer in cycle N+1.
- Data-path latency through the block is 0 cycles (combinational mux). There are no registers in tdata/tvalid/tlast/tready paths.
- Inter-frame gap is at least one IDLE cycle between consecutive frames, including back-to-back frames from the same port. This gives 1 bubble per frame.
- Single-byte frame (tvalid and tlast on the first beat): occupies exactly one XFER cycle when m_axis_tready=1.
- MAC backpressure (m_axis_tready=0) freezes the transfer. Data and tlast must remain stable; that is the source's obligation.
- Reset mid-frame asynchronously returns the block to IDLE:
  - The output stream is truncated without tlast.
  - The downstream MAC is expected to be reset by the same rst_n.
- tx_frame_cnt wraps from 2^CNT_W-1 to 0.

## Configuration
- TX_ARB_STRICT_PRIO_EN defined:
  - IDLE selection is fixed priority: the lowest-index valid port wins.
  - last_grant is unused and the search start is always 0.
  - Port 0 (the ICMP echo engine in the top level) can starve the higher-index ports.
- TX_ARB_STRICT_PRIO_EN undefined: round-robin as described in Operation.
- All other behaviour and timing are identical in both builds.

## Test plan
- Single-port frame:
  - Stimulus: after reset, port 1 sends a 53-byte ICMP reply with m_axis_tready=1.
  - Required response: the first byte appears on m_axis one cycle after tvalid is asserted. All 53 bytes arrive in order with tlast on byte 53. Then tx_frame_cnt=1, busy=0 and grant_id=1.
- Three-port contention:
  - Stimulus: all three ports hold a 4-byte frame valid at the same time.
  - Required response (round-robin build): output order is port 0, then 1, then 2, with exactly one idle cycle between frames. tx_frame_cnt=3.
- Strict-priority build:
  - Stimulus: port 0 continuously re-requests while port 2 is also valid.
  - Required response: port 0 wins every arbitration. Port 2's s_axis_tready stays 0.
- Backpressure:
  - Stimulus: toggle m_axis_tready 1,0,0,1 during a frame.
  - Required response: no bytes are lost or duplicated. s_axis_tready of the granted port mirrors m_axis_tready. Non-granted ready bits stay 0.
- Reset mid-frame:
  - Stimulus: deassert rst_n at byte 10 of 20.
  - Required response: immediately m_axis_tvalid=0 and all ready bits are 0. After reset release, the next contention among all ports is won by port 0.
- Counter wrap:
  - Stimulus: CNT_W=4; send 17 one-byte frames.
  - Required response: tx_frame_cnt reads 0 after frame 16 and 1 after frame 17.
